brick_raster: RTL

- Sequencer that walks the brick memory grid and turns each brick's health into a per-pixel plot stream (x, y, colour, writeEn).
- Sits between brick memory (upstream, read port) and the draw multiplexer's brick input (downstream).
- Started by a one-cycle go from the top-level draw FSM. Raises done when the whole grid is plotted; the FSM stays in its brick-draw state until done, not for a fixed delay.

---
 rtl/brick_raster.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/brick_raster.sv
// Brick grid rasteriser: walks brick memory one brick at a time and emits a
// per-pixel plot stream (x, y, colour, writeEn) coloured by each brick's health.
module brick_raster #(
   parameter int GRID_X   = 16,
   parameter int GRID_Y   = 4,
   parameter int BRICK_W  = 10,
   parameter int BRICK_H  = 5,
   parameter int ORIGIN_X = 0,
   parameter int ORIGIN_Y = 8
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       go,
   input  logic       skip_dead,
   output logic [5:0] mem_addr,
   input  logic [1:0] mem_health,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic [2:0] colour,
   output logic       writeEn,
   output logic       busy,
   output logic       done
);

   localparam logic [5:0] LAST_IDX = 6'(GRID_X * GRID_Y - 1);
   localparam logic [5:0] LAST_COL = 6'(GRID_X - 1);
   localparam logic [9:0] LAST_PX  = 10'(BRICK_W - 1);
   localparam logic [9:0] LAST_PY  = 10'(BRICK_H - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LATCH, S_DRAW, S_NEXT, S_DONE
   } state_t;

   state_t     r_state, w_state_next;
   logic [5:0] r_idx,  w_idx_next;
   logic [5:0] r_col,  w_col_next;
   logic [5:0] r_row,  w_row_next;
   logic [9:0] r_px,   w_px_next;
   logic [9:0] r_py,   w_py_next;
   logic [1:0] r_hreg, w_hreg_next;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_col   <= '0;
         r_row   <= '0;
         r_px    <= '0;
         r_py    <= '0;
         r_hreg  <= '0;
      end else begin
         r_state <= w_state_next;
         r_idx   <= w_idx_next;
         r_col   <= w_col_next;
         r_row   <= w_row_next;
         r_px    <= w_px_next;
         r_py    <= w_py_next;
         r_hreg  <= w_hreg_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_idx_next   = r_idx;
      w_col_next   = r_col;
      w_row_next   = r_row;
      w_px_next    = r_px;
      w_py_next    = r_py;
      w_hreg_next  = r_hreg;
      unique case (r_state)
         S_IDLE: begin
            if (go) begin
               w_idx_next   = '0;
               w_col_next   = '0;
               w_row_next   = '0;
               w_state_next = S_FETCH;
            end
         end
         S_FETCH: w_state_next = S_LATCH;
         S_LATCH: begin
            // Health is captured here so later memory writes cannot alter this brick.
            w_hreg_next  = mem_health;
            w_px_next    = '0;
            w_py_next    = '0;
            w_state_next = (mem_health == 2'd0 && skip_dead) ? S_NEXT : S_DRAW;
         end
         S_DRAW: begin
            if (r_px == LAST_PX) begin
               w_px_next = '0;
               if (r_py == LAST_PY) begin
                  w_py_next    = '0;
                  w_state_next = S_NEXT;
               end else begin
                  w_py_next = r_py + 10'd1;
               end
            end else begin
               w_px_next = r_px + 10'd1;
            end
         end
         S_NEXT: begin
            if (r_idx == LAST_IDX) begin
               w_state_next = S_DONE;
            end else begin
               w_idx_next = r_idx + 6'd1;
               if (r_col == LAST_COL) begin
                  w_col_next = '0;
                  w_row_next = r_row + 6'd1;
               end else begin
                  w_col_next = r_col + 6'd1;
               end
               w_state_next = S_FETCH;
            end
         end
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   logic [9:0] w_pix_x, w_pix_y;
   logic [2:0] w_pix_colour;
   logic       w_gap;

   assign w_pix_x = 10'(ORIGIN_X) + 10'(r_col * BRICK_W) + r_px;
   assign w_pix_y = 10'(ORIGIN_Y) + 10'(r_row * BRICK_H) + r_py;
   assign w_gap   = (r_px == LAST_PX) || (r_py == LAST_PY);

   always_comb begin
      w_pix_colour = 3'b000;
      if (!w_gap) begin
         unique case (r_hreg)
            2'd3:    w_pix_colour = 3'b100;
            2'd2:    w_pix_colour = 3'b110;
            2'd1:    w_pix_colour = 3'b010;
            default: w_pix_colour = 3'b000;
         endcase
      end
   end

   // Pixel bus is zeroed outside DRAW so it reads 0 after reset.
   assign writeEn  = (r_state == S_DRAW);
   assign x        = writeEn ? w_pix_x : 10'd0;
   assign y        = writeEn ? w_pix_y : 10'd0;
   assign colour   = writeEn ? w_pix_colour : 3'b000;
   assign busy     = (r_state != S_IDLE);
   assign done     = (r_state == S_DONE);
   assign mem_addr = r_idx;

endmodule
